// File: rtl/pipe_ctrl.sv
// Hazard/stall controller for a 5-stage pipeline: load-use bubbles, branch flushes and MEM-stage bus wait with timeout.
// Optional performance counters are compiled in when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic        load_use,
  input  logic        ex_jump,
  input  logic        mem_req,
  input  logic        bus_ack,
  output logic        pc_stall,
  output logic        ifid_stall,
  output logic        idex_stall,
  output logic        exmem_stall,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        memwb_flush,
  output logic        mem_busy,
  output logic        bus_err
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] perf_stall_cyc,
  output logic [31:0] perf_flush_cnt,
  output logic [31:0] perf_wait_cyc
`endif
);

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  localparam logic [7:0] WaitLast = 8'(MEM_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;

  logic in_wait;
  logic timeout;
  logic ack_valid;
  logic freeze;
  logic jump_flush;

  assign in_wait   = (state_q == MEM_WAIT);
  assign timeout   = in_wait && (wait_cnt_q == WaitLast);
  assign ack_valid = mem_req && bus_ack;
  assign freeze    = mem_req && !bus_ack && !timeout;
  assign jump_flush = !cpu_rst && !freeze && ex_jump;

  // Priority: reset > freeze > jump > load-use; timeout only adds the write-back kill.
  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    idex_stall  = 1'b0;
    exmem_stall = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    memwb_flush = 1'b0;
    if (cpu_rst) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      memwb_flush = 1'b1;
    end else if (freeze) begin
      pc_stall    = 1'b1;
      ifid_stall  = 1'b1;
      idex_stall  = 1'b1;
      exmem_stall = 1'b1;
      memwb_flush = 1'b1;
    end else begin
      if (ex_jump) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (load_use) begin
        pc_stall   = 1'b1;
        ifid_stall = 1'b1;
        idex_flush = 1'b1;
      end
      if (timeout) begin
        memwb_flush = 1'b1;
      end
    end
  end

  assign mem_busy = !cpu_rst && in_wait;
  assign bus_err  = !cpu_rst && timeout;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      RUN: begin
        wait_cnt_d = 8'd0;
        if (freeze) begin
          state_d = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (ack_valid || timeout) begin
          state_d    = RUN;
          wait_cnt_d = 8'd0;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = 8'd0;
      end
    endcase
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state_q    <= RUN;
      wait_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cyc_q, flush_cnt_q, wait_cyc_q;

  // Saturating event counters; they never wrap back to zero.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      stall_cyc_q <= 32'd0;
      flush_cnt_q <= 32'd0;
      wait_cyc_q  <= 32'd0;
    end else begin
      if (pc_stall && (stall_cyc_q != 32'hFFFF_FFFF)) begin
        stall_cyc_q <= stall_cyc_q + 32'd1;
      end
      if (jump_flush && (flush_cnt_q != 32'hFFFF_FFFF)) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
      if (in_wait && (wait_cyc_q != 32'hFFFF_FFFF)) begin
        wait_cyc_q <= wait_cyc_q + 32'd1;
      end
    end
  end

  assign perf_stall_cyc = stall_cyc_q;
  assign perf_flush_cnt = flush_cnt_q;
  assign perf_wait_cyc  = wait_cyc_q;
`else
  logic unused_jump_flush;
  assign unused_jump_flush = jump_flush;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl (built with MEM_TIMEOUT=4).
module tb_pipe_ctrl;

  logic cpu_clk = 1'b0;
  logic cpu_rst, load_use, ex_jump, mem_req, bus_ack;
  logic pc_stall, ifid_stall, idex_stall, exmem_stall;
  logic ifid_flush, idex_flush, memwb_flush, mem_busy, bus_err;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_cyc, perf_flush_cnt, perf_wait_cyc;
`endif

  int total = 0;
  int bad   = 0;

  always #5 cpu_clk = ~cpu_clk;

  pipe_ctrl #(.MEM_TIMEOUT(4)) dut (
    .cpu_clk     (cpu_clk),
    .cpu_rst     (cpu_rst),
    .load_use    (load_use),
    .ex_jump     (ex_jump),
    .mem_req     (mem_req),
    .bus_ack     (bus_ack),
    .pc_stall    (pc_stall),
    .ifid_stall  (ifid_stall),
    .idex_stall  (idex_stall),
    .exmem_stall (exmem_stall),
    .ifid_flush  (ifid_flush),
    .idex_flush  (idex_flush),
    .memwb_flush (memwb_flush),
    .mem_busy    (mem_busy),
    .bus_err     (bus_err)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .perf_stall_cyc (perf_stall_cyc),
    .perf_flush_cnt (perf_flush_cnt),
    .perf_wait_cyc  (perf_wait_cyc)
`endif
  );

  // Output vector order: {pc_stall, ifid_stall, idex_stall, exmem_stall, ifid_flush, idex_flush, memwb_flush, mem_busy, bus_err}
  localparam logic [8:0] O_IDLE  = 9'b0000_000_00;
  localparam logic [8:0] O_RST   = 9'b0000_111_00;
  localparam logic [8:0] O_LU    = 9'b1100_010_00;
  localparam logic [8:0] O_JMP   = 9'b0000_110_00;
  localparam logic [8:0] O_FRZ   = 9'b1111_001_00;
  localparam logic [8:0] O_FRZW  = 9'b1111_001_10;
  localparam logic [8:0] O_ACKW  = 9'b0000_000_10;
  localparam logic [8:0] O_ACKJ  = 9'b0000_110_10;
  localparam logic [8:0] O_ACKL  = 9'b1100_010_10;
  localparam logic [8:0] O_TOUT  = 9'b0000_001_11;

  function automatic logic [8:0] outs();
    return {pc_stall, ifid_stall, idex_stall, exmem_stall,
            ifid_flush, idex_flush, memwb_flush, mem_busy, bus_err};
  endfunction

  // Apply one cycle of inputs just after the falling edge; outputs settle 1 time unit later.
  task automatic drive(input logic rst, input logic lu, input logic jmp,
                       input logic req, input logic ack);
    @(negedge cpu_clk);
    cpu_rst = rst; load_use = lu; ex_jump = jmp; mem_req = req; bus_ack = ack;
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0);
      total++;
      if (outs() !== O_RST) begin
        $display("FAIL reset_hold[%0d] got=%b want=%b", i, outs(), O_RST); bad++;
      end
    end
    drive(0, 0, 0, 0, 0);
    total++;
    if (outs() !== O_IDLE) begin
      $display("FAIL reset_release got=%b want=%b", outs(), O_IDLE); bad++;
    end
    $display("test_reset done");
  endtask

  task automatic test_load_use();
    logic [8:0] exp_v [4] = '{O_LU, O_IDLE, O_JMP, O_JMP};
    logic       lu_v  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic       jmp_v [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      drive(0, lu_v[i], jmp_v[i], 0, 0);
      total++;
      if (outs() !== exp_v[i]) begin
        $display("FAIL load_use_jump[%0d] got=%b want=%b", i, outs(), exp_v[i]); bad++;
      end
    end
    $display("test_load_use done");
  endtask

  task automatic test_mem_ack();
    logic [8:0] exp_v [5] = '{O_FRZ, O_FRZW, O_FRZW, O_ACKW, O_IDLE};
    logic       req_v [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic       ack_v [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, req_v[i], ack_v[i]);
      total++;
      if (outs() !== exp_v[i]) begin
        $display("FAIL mem_ack[c%0d] got=%b want=%b", i + 1, outs(), exp_v[i]); bad++;
      end
    end
    $display("test_mem_ack done");
  endtask

  task automatic test_timeout();
    logic [8:0] exp_v [7] = '{O_FRZ, O_FRZW, O_FRZW, O_FRZW, O_TOUT, O_IDLE, O_IDLE};
    logic       req_v [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 7; i++) begin
      drive(0, 0, 0, req_v[i], 0);
      total++;
      if (outs() !== exp_v[i]) begin
        $display("FAIL timeout[c%0d] got=%b want=%b", i + 1, outs(), exp_v[i]); bad++;
      end
    end
    $display("test_timeout done");
  endtask

  task automatic test_jump_in_freeze();
    logic [8:0] exp_v [5] = '{O_FRZ, O_FRZW, O_ACKJ, O_IDLE, O_ACKL};
    logic       lu_v  [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic       jmp_v [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       req_v [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic       ack_v [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      drive(0, lu_v[i], jmp_v[i], req_v[i], ack_v[i]);
      if (i == 4) begin
        // Cycle 4 entered a new MEM_WAIT only if req was high; step 5 relies on that frozen entry.
      end
      total++;
      if (outs() !== ((i == 4) ? O_FRZ : exp_v[i])) begin
        $display("FAIL jump_in_freeze[c%0d] got=%b want=%b", i + 1, outs(),
                 (i == 4) ? O_FRZ : exp_v[i]); bad++;
      end
    end
    // Now in MEM_WAIT: ack arrives together with load_use, which is evaluated normally.
    drive(0, 1, 0, 1, 1);
    total++;
    if (outs() !== O_ACKL) begin
      $display("FAIL ack_with_load_use got=%b want=%b", outs(), O_ACKL); bad++;
    end
    drive(0, 0, 0, 0, 0);
    total++;
    if (outs() !== O_IDLE) begin
      $display("FAIL after_ack_idle got=%b want=%b", outs(), O_IDLE); bad++;
    end
    $display("test_jump_in_freeze done");
  endtask

  task automatic test_zero_wait();
    drive(0, 0, 0, 1, 1);
    total++;
    if (outs() !== O_IDLE) begin
      $display("FAIL zero_wait got=%b want=%b", outs(), O_IDLE); bad++;
    end
    drive(0, 0, 0, 0, 1);
    total++;
    if (outs() !== O_IDLE) begin
      $display("FAIL ack_without_req got=%b want=%b", outs(), O_IDLE); bad++;
    end
    drive(0, 0, 0, 0, 0);
    total++;
    if (outs() !== O_IDLE) begin
      $display("FAIL zero_wait_after got=%b want=%b", outs(), O_IDLE); bad++;
    end
    $display("test_zero_wait done");
  endtask

  task automatic test_reset_in_wait();
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0);
    total++;
    if (outs() !== O_FRZW) begin
      $display("FAIL rst_wait_entry got=%b want=%b", outs(), O_FRZW); bad++;
    end
    drive(1, 0, 0, 1, 0);
    total++;
    if (outs() !== O_RST) begin
      $display("FAIL rst_in_wait got=%b want=%b", outs(), O_RST); bad++;
    end
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 0, 0);
      total++;
      if (outs() !== O_IDLE) begin
        $display("FAIL rst_wait_after[%0d] got=%b want=%b", i, outs(), O_IDLE); bad++;
      end
    end
    $display("test_reset_in_wait done");
  endtask

`ifdef PIPE_CTRL_PERF_EN
  task automatic test_perf();
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    total++;
    if ({perf_stall_cyc, perf_flush_cnt, perf_wait_cyc} !== 96'd0) begin
      $display("FAIL perf_clear got=%0d/%0d/%0d want=0/0/0",
               perf_stall_cyc, perf_flush_cnt, perf_wait_cyc); bad++;
    end
    for (int i = 0; i < 5; i++) drive(0, 1, 0, 0, 0);
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 1);
    drive(0, 0, 0, 0, 0);
    total++;
    if (perf_stall_cyc !== 32'd8 || perf_flush_cnt !== 32'd2 || perf_wait_cyc !== 32'd3) begin
      $display("FAIL perf_counts got=%0d/%0d/%0d want=8/2/3",
               perf_stall_cyc, perf_flush_cnt, perf_wait_cyc); bad++;
    end
    $display("test_perf done");
  endtask
`endif

  initial begin
    cpu_rst = 1'b1; load_use = 1'b0; ex_jump = 1'b0; mem_req = 1'b0; bus_ack = 1'b0;
    test_reset();
    test_load_use();
    test_mem_ack();
    test_timeout();
    test_jump_in_freeze();
    test_zero_wait();
    test_reset_in_wait();
`ifdef PIPE_CTRL_PERF_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
